// File: rtl/score_counter_if.sv
// score_counter_if
//   Groups the game-event inputs, the pixel position and the score/digit
//   outputs of score_counter into one bundle.
//   master : game logic / video timing side (drives events and i_hpos)
//   slave  : score_counter (drives score, high score and digit-select outputs)
//   Signals:
//     i_frame_tick, i_start, i_game_over  1-cycle event pulses
//     i_hpos [9:CONV]                     current horizontal pixel position
//     o_score, o_hiscore [15:0]           packed BCD {d3,d2,d1,d0}
//     o_running                           game in progress
//     o_num [3:0], o_cell, o_blank        digit under i_hpos, cell hit, leading-zero blank
interface score_counter_if #(
  parameter int CONV = 0
);
  logic            i_frame_tick;
  logic            i_start;
  logic            i_game_over;
  logic [9:CONV]   i_hpos;
  logic [15:0]     o_score;
  logic [15:0]     o_hiscore;
  logic            o_running;
  logic [3:0]      o_num;
  logic            o_cell;
  logic            o_blank;

  modport master (
    output i_frame_tick, i_start, i_game_over, i_hpos,
    input  o_score, o_hiscore, o_running, o_num, o_cell, o_blank
  );

  modport slave (
    input  i_frame_tick, i_start, i_game_over, i_hpos,
    output o_score, o_hiscore, o_running, o_num, o_cell, o_blank
  );
endinterface

// File: rtl/score_counter.sv
// score_counter
//   Game-side producer of the score digits for the digit renderer. Keeps a
//   4-digit saturating BCD score advanced by frame ticks while running, a high
//   score captured at game over, and a registered per-pixel digit select.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    score_counter_if.slave (events, i_hpos in; score/digit outputs)
//
//   state | meaning
//   IDLE  | after reset, waiting for the first start
//   RUN   | game in progress, frame ticks advance the score
//   OVER  | game ended, score frozen until the next start
module score_counter #(
  parameter int CONV       = 0,
  parameter int FRAMES_PER = 6,
  parameter int X_BASE     = 28,
  parameter int PITCH      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  score_counter_if.slave bus
);

  localparam int HW  = 10 - CONV;
  localparam int FCW = (FRAMES_PER > 1) ? $clog2(FRAMES_PER) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [15:0]     score_q, score_nxt;
  logic [15:0]     hi_q, hi_nxt;
  logic [FCW-1:0]  frame_q, frame_nxt;

  // Ripple BCD +1; caller guarantees the input is not 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      score_q <= 16'h0000;
      hi_q    <= 16'h0000;
      frame_q <= '0;
    end else begin
      state   <= state_nxt;
      score_q <= score_nxt;
      hi_q    <= hi_nxt;
      frame_q <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    score_nxt = score_q;
    hi_nxt    = hi_q;
    frame_nxt = frame_q;
    case (state)
      IDLE, OVER: begin
        if (bus.i_start) begin
          state_nxt = RUN;
          score_nxt = 16'h0000;
          frame_nxt = '0;
        end
      end
      RUN: begin
        if (bus.i_start) begin
          score_nxt = 16'h0000;
          frame_nxt = '0;
        end else if (bus.i_game_over) begin
          // Packed BCD orders the same as its binary value.
          state_nxt = OVER;
          if (score_q > hi_q) hi_nxt = score_q;
        end else if (bus.i_frame_tick) begin
          if (frame_q == FCW'(FRAMES_PER - 1)) begin
            frame_nxt = '0;
            if (score_q != 16'h9999) score_nxt = bcd_inc(score_q);
          end else begin
            frame_nxt = frame_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit select: rel wraps high left of X_BASE and falls out of range.
  logic [HW-1:0] rel, col;
  logic [1:0]    k;
  logic          in_rng, cell_d, lead_zero;
  logic [3:0]    sel;

  always_comb begin
    rel    = bus.i_hpos - HW'(X_BASE);
    k      = 2'd0;
    col    = rel;
    in_rng = 1'b1;
    if (rel < HW'(PITCH)) begin
      k   = 2'd0;
      col = rel;
    end else if (rel < HW'(2 * PITCH)) begin
      k   = 2'd1;
      col = rel - HW'(PITCH);
    end else if (rel < HW'(3 * PITCH)) begin
      k   = 2'd2;
      col = rel - HW'(2 * PITCH);
    end else if (rel < HW'(4 * PITCH)) begin
      k   = 2'd3;
      col = rel - HW'(3 * PITCH);
    end else begin
      in_rng = 1'b0;
    end
    cell_d = in_rng && (col < HW'(4));

    sel       = 4'd0;
    lead_zero = 1'b0;
    case (k)
      2'd0: begin sel = score_q[15:12]; lead_zero = (score_q[15:12] == 4'd0); end
      2'd1: begin sel = score_q[11:8];  lead_zero = (score_q[15:8]  == 8'd0); end
      2'd2: begin sel = score_q[7:4];   lead_zero = (score_q[15:4]  == 12'd0); end
      default: begin sel = score_q[3:0]; lead_zero = 1'b0; end
    endcase
  end

  logic [3:0] num_q;
  logic       cell_q, blank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q   <= 4'd0;
      cell_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      num_q   <= cell_d ? sel : 4'd0;
      cell_q  <= cell_d;
      blank_q <= cell_d && lead_zero;
    end
  end

  assign bus.o_score   = score_q;
  assign bus.o_hiscore = hi_q;
  assign bus.o_running = (state == RUN);
  assign bus.o_num     = num_q;
  assign bus.o_cell    = cell_q;
  assign bus.o_blank   = blank_q;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter
//   Directed bench for score_counter. Main instance uses the default
//   parameters; a second instance with FRAMES_PER=1 reaches saturation quickly.
module tb_score_counter;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  score_counter_if sb ();
  score_counter_if fb ();

  score_counter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb)
  );

  score_counter #(.FRAMES_PER(1)) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    @(negedge clk) sb.i_start = 1'b1;
    @(negedge clk) sb.i_start = 1'b0;
  endtask

  task automatic pulse_over();
    @(negedge clk) sb.i_game_over = 1'b1;
    @(negedge clk) sb.i_game_over = 1'b0;
  endtask

  // Holds the tick high for n consecutive clock edges.
  task automatic ticks(input int n);
    if (n > 0) begin
      @(negedge clk) sb.i_frame_tick = 1'b1;
      repeat (n) @(negedge clk);
      sb.i_frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (sb.o_score !== 16'h0 || sb.o_hiscore !== 16'h0 || sb.o_running !== 1'b0 ||
        sb.o_num !== 4'd0 || sb.o_blank !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: score=%h hi=%h run=%b num=%h blank=%b", sb.o_score,
               sb.o_hiscore, sb.o_running, sb.o_num, sb.o_blank);
    end
    for (int h = 20; h < 50; h++) begin
      @(negedge clk) sb.i_hpos = 10'(h);
      @(negedge clk);
      checks++;
      if (sb.o_cell !== 1'b0) begin
        errors++;
        $display("FAIL reset_cell h=%0d: cell=%b want 0", h, sb.o_cell);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (sb.o_score !== 16'h0 || sb.o_hiscore !== 16'h0 || sb.o_running !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: score=%h hi=%h run=%b", sb.o_score, sb.o_hiscore,
               sb.o_running);
    end
  endtask

  task automatic test_count();
    ticks(12);
    checks++;
    if (sb.o_score !== 16'h0000 || sb.o_running !== 1'b0) begin
      errors++;
      $display("FAIL idle_ticks: score=%h run=%b want 0000 0", sb.o_score, sb.o_running);
    end
    pulse_start();
    checks++;
    if (sb.o_running !== 1'b1) begin
      errors++;
      $display("FAIL start_running: run=%b want 1", sb.o_running);
    end
    ticks(5);
    checks++;
    if (sb.o_score !== 16'h0000) begin
      errors++;
      $display("FAIL five_ticks: score=%h want 0000", sb.o_score);
    end
    ticks(7);
    checks++;
    if (sb.o_score !== 16'h0002) begin
      errors++;
      $display("FAIL twelve_ticks: score=%h want 0002", sb.o_score);
    end
  endtask

  task automatic test_bcd();
    pulse_start();
    checks++;
    if (sb.o_score !== 16'h0000 || sb.o_running !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: score=%h run=%b want 0000 1", sb.o_score, sb.o_running);
    end
    ticks(9 * 6);
    checks++;
    if (sb.o_score !== 16'h0009) begin
      errors++;
      $display("FAIL bcd_0009: score=%h want 0009", sb.o_score);
    end
    ticks(6);
    checks++;
    if (sb.o_score !== 16'h0010) begin
      errors++;
      $display("FAIL bcd_0010: score=%h want 0010", sb.o_score);
    end
    ticks(89 * 6);
    checks++;
    if (sb.o_score !== 16'h0099) begin
      errors++;
      $display("FAIL bcd_0099: score=%h want 0099", sb.o_score);
    end
    ticks(6);
    checks++;
    if (sb.o_score !== 16'h0100) begin
      errors++;
      $display("FAIL bcd_0100: score=%h want 0100", sb.o_score);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk) fb.i_start = 1'b1;
    @(negedge clk) begin fb.i_start = 1'b0; fb.i_frame_tick = 1'b1; end
    repeat (9998) @(negedge clk);
    checks++;
    if (fb.o_score !== 16'h9998) begin
      errors++;
      $display("FAIL sat_9998: score=%h want 9998", fb.o_score);
    end
    @(negedge clk);
    checks++;
    if (fb.o_score !== 16'h9999) begin
      errors++;
      $display("FAIL sat_9999: score=%h want 9999", fb.o_score);
    end
    repeat (6) @(negedge clk);
    fb.i_frame_tick = 1'b0;
    checks++;
    if (fb.o_score !== 16'h9999) begin
      errors++;
      $display("FAIL sat_hold: score=%h want 9999", fb.o_score);
    end
  endtask

  task automatic test_game_over();
    pulse_start();
    ticks(42 * 6 + 5);
    checks++;
    if (sb.o_score !== 16'h0042) begin
      errors++;
      $display("FAIL pre_over: score=%h want 0042", sb.o_score);
    end
    // Frame counter sits at its last value: a counted tick here would give 0043.
    @(negedge clk) begin sb.i_game_over = 1'b1; sb.i_frame_tick = 1'b1; end
    @(negedge clk) begin sb.i_game_over = 1'b0; sb.i_frame_tick = 1'b0; end
    checks++;
    if (sb.o_running !== 1'b0 || sb.o_hiscore !== 16'h0042 || sb.o_score !== 16'h0042) begin
      errors++;
      $display("FAIL over_capture: run=%b hi=%h score=%h want 0 0042 0042", sb.o_running,
               sb.o_hiscore, sb.o_score);
    end
    ticks(12);
    pulse_over();
    checks++;
    if (sb.o_score !== 16'h0042 || sb.o_hiscore !== 16'h0042 || sb.o_running !== 1'b0) begin
      errors++;
      $display("FAIL over_frozen: score=%h hi=%h run=%b", sb.o_score, sb.o_hiscore,
               sb.o_running);
    end
    pulse_start();
    checks++;
    if (sb.o_score !== 16'h0000 || sb.o_hiscore !== 16'h0042 || sb.o_running !== 1'b1) begin
      errors++;
      $display("FAIL over_restart: score=%h hi=%h run=%b want 0000 0042 1", sb.o_score,
               sb.o_hiscore, sb.o_running);
    end
    ticks(10 * 6);
    pulse_over();
    checks++;
    if (sb.o_score !== 16'h0010 || sb.o_hiscore !== 16'h0042) begin
      errors++;
      $display("FAIL lower_game: score=%h hi=%h want 0010 0042", sb.o_score, sb.o_hiscore);
    end
  endtask

  task automatic test_digits();
    logic [3:0] dig [4];
    logic       ecell, eblank, pcell;
    logic [3:0] enum_v;
    int         rel;
    dig[0] = 4'd0; dig[1] = 4'd3; dig[2] = 4'd0; dig[3] = 4'd5;
    pulse_start();
    ticks(305 * 6);
    checks++;
    if (sb.o_score !== 16'h0305) begin
      errors++;
      $display("FAIL score_0305: score=%h want 0305", sb.o_score);
    end
    @(negedge clk) sb.i_hpos = 10'd26;
    @(negedge clk);
    pcell = 1'b0;
    for (int h = 27; h <= 48; h++) begin
      rel    = h - 28;
      ecell  = (h >= 28) && (rel < 20) && ((rel % 5) < 4);
      enum_v = ecell ? dig[rel / 5] : 4'd0;
      eblank = ecell && (rel / 5 == 0);
      @(negedge clk) sb.i_hpos = 10'(h);
      #1;
      checks++;
      if (sb.o_cell !== pcell) begin
        errors++;
        $display("FAIL lag h=%0d: cell=%b want %b", h, sb.o_cell, pcell);
      end
      @(negedge clk);
      checks++;
      if (sb.o_cell !== ecell || sb.o_num !== enum_v || sb.o_blank !== eblank) begin
        errors++;
        $display("FAIL digit h=%0d: cell=%b num=%h blank=%b want %b %h %b", h, sb.o_cell,
                 sb.o_num, sb.o_blank, ecell, enum_v, eblank);
      end
      pcell = ecell;
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    ticks(77 * 6);
    @(negedge clk) sb.i_hpos = 10'd43;
    @(negedge clk);
    checks++;
    if (sb.o_score !== 16'h0077 || sb.o_num !== 4'd7 || sb.o_cell !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: score=%h num=%h cell=%b want 0077 7 1", sb.o_score,
               sb.o_num, sb.o_cell);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sb.o_score !== 16'h0 || sb.o_hiscore !== 16'h0 || sb.o_running !== 1'b0 ||
        sb.o_num !== 4'd0 || sb.o_cell !== 1'b0 || sb.o_blank !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: score=%h hi=%h run=%b num=%h cell=%b blank=%b",
               sb.o_score, sb.o_hiscore, sb.o_running, sb.o_num, sb.o_cell, sb.o_blank);
    end
    @(negedge clk) rst_n = 1'b1;
    sb.i_hpos = 10'd0;
    ticks(12);
    checks++;
    if (sb.o_score !== 16'h0 || sb.o_running !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: score=%h run=%b want 0000 0", sb.o_score,
               sb.o_running);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    sb.i_frame_tick = 1'b0;
    sb.i_start      = 1'b0;
    sb.i_game_over  = 1'b0;
    sb.i_hpos       = 10'd0;
    fb.i_frame_tick = 1'b0;
    fb.i_start      = 1'b0;
    fb.i_game_over  = 1'b0;
    fb.i_hpos       = 10'd0;
    test_reset();
    test_count();
    test_bcd();
    test_saturate();
    test_game_over();
    test_digits();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
